// File: rtl/efdr_stream_ctrl.sv
// EFDR stream controller: feeds compressed words bit-serially to the
// EFDR decoder and packs its decoded bits back into words.
module efdr_stream_ctrl #(
    parameter int WORD_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  target_len,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dec_bit_in,
    input  logic              dec_en,
    input  logic              dec_v,
    input  logic              dec_out,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic              overflow
);

    localparam int CW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] FULL = CW'(WORD_W);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t state;

    logic [WORD_W-1:0] in_shift;
    logic [CW-1:0]     in_cnt;
    logic [WORD_W-1:0] acc;
    logic [CW-1:0]     acc_cnt;
    logic [LEN_W-1:0]  dec_cnt;
    logic [LEN_W-1:0]  tlen;

    logic              take_bit;
    logic              word_full;
    logic              last_bit;
    logic              can_load;
    logic [WORD_W-1:0] acc_next;
    logic [CW-1:0]     acc_cnt_next;
    logic [WORD_W-1:0] flush_word;

    assign in_ready = (state == RUN) &&
                      ((in_cnt == '0) || ((in_cnt == ONE) && dec_en));

    assign dec_bit_in = (in_cnt != '0) && in_shift[WORD_W-1];

    // Decoded bits past the target count are ignored.
    assign take_bit     = (state == RUN) && dec_v && (dec_cnt < tlen);
    assign acc_next     = {acc[WORD_W-2:0], dec_out};
    assign acc_cnt_next = acc_cnt + ONE;
    assign word_full    = (acc_cnt_next == FULL);
    assign last_bit     = ((dec_cnt + LEN_W'(1)) == tlen);
    assign can_load     = !out_valid || out_ready;

    // Partial word is left-justified so the first decoded bit sits in the MSB.
    assign flush_word = acc << (FULL - acc_cnt);

    // Input shifter: a fresh load wins over the shift of the last held bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_shift <= '0;
            in_cnt   <= '0;
        end else if (state != RUN) begin
            in_shift <= '0;
            in_cnt   <= '0;
        end else if (in_valid && in_ready) begin
            in_shift <= in_data;
            in_cnt   <= FULL;
        end else if (dec_en && (in_cnt != '0)) begin
            in_shift <= in_shift << 1;
            in_cnt   <= in_cnt - ONE;
        end
    end

    // Session FSM with output packing and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            acc_cnt   <= '0;
            dec_cnt   <= '0;
            tlen      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tlen     <= target_len;
                        dec_cnt  <= '0;
                        acc      <= '0;
                        acc_cnt  <= '0;
                        underrun <= 1'b0;
                        overflow <= 1'b0;
                        if (target_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (dec_en && (in_cnt == '0)) begin
                        underrun <= 1'b1;
                    end
                    if (take_bit) begin
                        dec_cnt <= dec_cnt + LEN_W'(1);
                        if (word_full) begin
                            acc     <= '0;
                            acc_cnt <= '0;
                            if (can_load) begin
                                out_data  <= acc_next;
                                out_valid <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            acc     <= acc_next;
                            acc_cnt <= acc_cnt_next;
                        end
                        if (last_bit) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (acc_cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (can_load) begin
                        out_data  <= flush_word;
                        out_valid <= 1'b1;
                        acc       <= '0;
                        acc_cnt   <= '0;
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/efdr_stream_ctrl.md
Name: efdr_stream_ctrl

Overview:
- Sequencer wrapped around the serial EFDR decoder.
- Accepts compressed test data as WORD_W-bit words via valid/ready and serialises them MSB-first onto the decoder's bit_in, one bit each time the decoder raises en.
- Packs the decoder's output bits (out qualified by v) into WORD_W-bit words for downstream.
- Ends a session after target_len decoded bits and reports done, underrun and overflow status.

Parameters:
WORD_W, 8, width of compressed input words and packed output words
LEN_W, 16, width of the decoded-bit target counter

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin a session; sampled only in IDLE
target_len  in  LEN_W  decoded bits to produce; latched on accepted start
in_data  in  WORD_W  compressed word
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts in_data this cycle
dec_bit_in  out  1  to decoder bit_in
dec_en  in  1  decoder en: samples dec_bit_in at this edge
dec_v  in  1  decoder v: dec_out valid this cycle
dec_out  in  1  decoder out bit
out_data  out  WORD_W  packed decoded word, first decoded bit in MSB
out_valid  out  1  out_data valid; held until out_ready
out_ready  in  1  downstream accepts
busy  out  1  session active (RUN or FLUSH)
done  out  1  one-cycle pulse at session end
underrun  out  1  sticky: decoder requested a bit when none was held
overflow  out  1  sticky: packed word lost because out_data was still pending

Behaviour:
- Reset (synchronous, active-high, highest priority, also mid-session):
  - state=IDLE; every output, counter and shift register cleared to 0.
  - underrun and overflow also clear on an accepted start.
- States:
  - IDLE: accepted start goes to RUN, or straight to DONE if target_len=0. start seen while busy is ignored.
  - RUN → FLUSH when the decoded count reaches target_len.
  - FLUSH → DONE once the partial word (if any) has been handed to out_data.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Input side:
  - in_shift (WORD_W bits) plus in_cnt (bits remaining).
  - in_ready = (state==RUN) & (in_cnt==0 | (in_cnt==1 & dec_en)). Back-to-back words give no bubble.
  - Load on in_valid & in_ready: in_shift=in_data, in_cnt=WORD_W.
  - dec_bit_in = in_shift[MSB] when in_cnt>0, else 0.
  - On dec_en & in_cnt>0: shift left by one, in_cnt decrements. A simultaneous load takes priority over the shift.
  - On dec_en & in_cnt==0 in RUN: set underrun. The decoder consumes 0, and nothing else is altered.
  - dec_en outside RUN is ignored: no shift, no flag.
- Output side:
  - acc (WORD_W bits), acc_cnt, dec_cnt (LEN_W bits).
  - In RUN on dec_v: shift dec_out into acc LSB, increment acc_cnt and dec_cnt.
  - dec_v after dec_cnt==target_len is discarded.
- Word completion:
  - A word completes when acc_cnt reaches WORD_W. In FLUSH with acc_cnt>0, the partial word is left-justified and zero-padded.
  - If out_valid=0, or out_ready=1 this cycle: out_data=word and out_valid=1 on the next edge; acc_cnt is reset.
  - Otherwise in RUN: set overflow and drop the word.
  - In FLUSH the controller waits instead of dropping.
- out_valid clears on out_valid & out_ready unless a new word loads at the same edge.
- Latency: the last bit of a word on dec_v at edge N gives out_valid=1 after edge N.
- Arithmetic:
  - Counters are unsigned and never wrap; dec_cnt saturates at target_len.
  - Any input bits left over at session end are discarded.
  - in_ready=0 outside RUN.

Test Plan:
- reset, then start with target_len=8. Feed in_data=8'hE4; drive dec_en for 8 cycles, then dec_v with bits 1,0,1,1,0,0,1,0 → dec_bit_in sequence 1,1,1,0,0,1,0,0. Then out_data=8'hB2 and out_valid=1; then FLUSH with nothing pending, done pulses once, busy=0.
- target_len=12 with 12 dec_v bits all 1 → words 8'hFF then 8'hF0 (zero-padded); done only after the second word is accepted.
- dec_en asserted with in_valid=0 and in_cnt=0 → underrun=1 and stays 1, dec_bit_in=0; the next start clears it.
- out_ready=0 while 16 decoded bits arrive → the first word is held, the second is dropped, overflow=1, out_data unchanged.
- Two words with in_valid held high and dec_en every cycle → in_ready pulses on the last-bit cycle; 16 consecutive bits with no gap.
- reset asserted mid-RUN → next cycle all outputs 0 and state IDLE. target_len=0 start → done pulses on the second cycle, out_valid never rises.
